// File: rtl/fpu_sequencer_pkg.sv
// fpu_sequencer_pkg
//   Shared definitions for the FPU sequencer slice:
//   - fpu_op_e     : operation encoding carried on reqN_op / fpu_control
//   - seq_state_e  : sequencer FSM state encoding
//   - DEF_LAT_*    : default accept-to-capture latencies (valid range 1..15)
package fpu_sequencer_pkg;

  typedef enum logic [1:0] {
    FPU_ADDSUB = 2'b00,
    FPU_MUL    = 2'b01,
    FPU_DIV    = 2'b10,
    FPU_SQRT   = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } seq_state_e;

  localparam int unsigned DEF_LAT_ADDSUB = 1;
  localparam int unsigned DEF_LAT_MUL    = 2;
  localparam int unsigned DEF_LAT_DIV    = 6;
  localparam int unsigned DEF_LAT_SQRT   = 8;

endpackage

// File: rtl/fpu_sequencer_rr_arbiter2.sv
// rr_arbiter2
//   Two-requester round-robin arbiter, purely combinational.
//   valid_i      : request present, bit N = requester N
//   last_grant_i : index of the requester granted most recently
//   grant_o      : one-hot grant (all zero when no request)
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Contention: favour whoever did not win last time.
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer
//   Arbitrates two requesters onto a shared combinational FPU datapath,
//   keeps one operation in flight, waits a per-op latency, then presents
//   the captured result on a valid/ready response channel.
//   clk, rst_n                   : clock (rising edge), async active-low reset
//   reqN_valid/ready             : request handshake for requester N
//   reqN_op/sel/rs1/rs2          : operation, add/sub select, operands
//   fpu_rs1/rs2/control/sel      : registered drive of the FPU datapath
//   fpu_result                   : FPU datapath result
//   rsp_valid/ready/id/data      : response handshake, winner index, result
//   busy                         : high whenever not IDLE
module fpu_sequencer
  import fpu_sequencer_pkg::*;
#(
  parameter int unsigned LAT_ADDSUB = DEF_LAT_ADDSUB,
  parameter int unsigned LAT_MUL    = DEF_LAT_MUL,
  parameter int unsigned LAT_DIV    = DEF_LAT_DIV,
  parameter int unsigned LAT_SQRT   = DEF_LAT_SQRT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic        req0_sel,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic        req1_sel,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [1:0]  fpu_control,
  output logic        fpu_sel,
  input  logic [31:0] fpu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);

  seq_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        last_grant_q;
  logic [31:0] fpu_rs1_q, fpu_rs2_q, rsp_data_q;
  logic [1:0]  fpu_control_q;
  logic        fpu_sel_q, rsp_id_q;

  logic [1:0]  grant;
  logic        accept;
  logic        win;
  logic [1:0]  win_op;

  // Counter preload is LAT-1 so that capture lands exactly LAT edges after accept.
  function automatic logic [3:0] lat_m1(input fpu_op_e op);
    case (op)
      FPU_ADDSUB: lat_m1 = 4'(LAT_ADDSUB - 1);
      FPU_MUL:    lat_m1 = 4'(LAT_MUL - 1);
      FPU_DIV:    lat_m1 = 4'(LAT_DIV - 1);
      default:    lat_m1 = 4'(LAT_SQRT - 1);
    endcase
  endfunction

  rr_arbiter2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Ready is gated by rst_n so both stay low throughout reset.
  assign req0_ready = rst_n && (state_q == ST_IDLE) && grant[0];
  assign req1_ready = rst_n && (state_q == ST_IDLE) && grant[1];
  assign accept     = req0_ready || req1_ready;
  assign win        = grant[1];
  assign win_op     = win ? req1_op : req0_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      fpu_rs1_q     <= '0;
      fpu_rs2_q     <= '0;
      fpu_control_q <= '0;
      fpu_sel_q     <= 1'b0;
      rsp_data_q    <= '0;
      rsp_id_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            fpu_rs1_q     <= win ? req1_rs1 : req0_rs1;
            fpu_rs2_q     <= win ? req1_rs2 : req0_rs2;
            fpu_control_q <= win_op;
            fpu_sel_q     <= win ? req1_sel : req0_sel;
            rsp_id_q      <= win;
            last_grant_q  <= win;
            cnt_q         <= lat_m1(fpu_op_e'(win_op));
            state_q       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q <= fpu_result;
            state_q    <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fpu_rs1     = fpu_rs1_q;
  assign fpu_rs2     = fpu_rs2_q;
  assign fpu_control = fpu_control_q;
  assign fpu_sel     = fpu_sel_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);

endmodule
